// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: one root bit per clock, start/done handshake.
// Define ISQRT_EXACT_FLAG_EN to register a perfect-square flag on `exact`; otherwise it is tied low.
module isqrt_seq #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem,
  output logic               exact
);
  localparam int R  = WIDTH / 2;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [R-1:0]   q_q, q_d;
  logic [R-1:0]   p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [R-1:0]   root_q, root_d;
  logic [R:0]     rem_q, rem_d;

  logic [R+1:0]   t, d, diff;
  logic [R:0]     p_next;
  logic           ge, accept, finish;

  // Partial remainder entering any iteration is <= 2*q with q < 2^(R-1), so R bits suffice.
  always_comb begin
    t      = {p_q, x_q[WIDTH-1 -: 2]};
    d      = {q_q, 2'b01};
    diff   = t - d;
    ge     = (t >= d);
    p_next = (R+1)'(ge ? diff : t);
    accept = start && ((state_q == IDLE) || (state_q == DONE));
    finish = (state_q == CALC) && (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      q_q     <= q_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    q_d    = q_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    root_d = root_q;
    rem_d  = rem_q;
    if (accept) begin
      x_d   = value;
      q_d   = '0;
      p_d   = '0;
      cnt_d = CW'(R - 1);
    end else if (state_q == CALC) begin
      x_d   = x_q << 2;
      q_d   = R'({q_q, ge});
      p_d   = p_next[R-1:0];
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
    if (finish) begin
      root_d = R'({q_q, ge});
      rem_d  = p_next;
    end
  end

`ifdef ISQRT_EXACT_FLAG_EN
  logic exact_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      exact_q <= 1'b0;
    else if (finish) exact_q <= (p_next == '0);
  end
  assign exact = exact_q;
`else
  assign exact = 1'b0;
`endif

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
    root = root_q;
    rem  = rem_q;
  end
endmodule

// File: doc/isqrt_seq.md
Name: isqrt_seq

Overview:
- Sequential integer square root; the inverse of the lab squarer.
- Takes an unsigned WIDTH-bit value and returns its floor square root and remainder.
- Computes one root bit per clock using the restoring digit-by-digit method, with a start/done handshake.
- Intended to drive LEDR from SW on the lab board, or to sit behind a squarer in a self-check loop.

Parameters:
- WIDTH, 6, input value width; must be even and >= 2. Root width is R = WIDTH/2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when idle or in the done cycle.
- value  input  WIDTH  radicand; captured on the accepting edge.
- busy  output  1  high while iterating.
- done  output  1  single-cycle pulse when root/rem are valid.
- root  output  R  floor(sqrt(value)).
- rem  output  R+1  value - root*root; always <= 2*root.
- exact  output  1  high when rem == 0; see Optional Feature.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, root=0, rem=0, exact=0; internal shift/partial registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 -> capture value into shift register x; clear partial root q and partial remainder p; load counter with R-1; go to CALC.
  - start=0 -> stay in IDLE.
- CALC, one iteration per cycle:
  - t = {p, x[WIDTH-1:WIDTH-2]}, computed at R+2 bits.
  - d = {q, 2'b01}.
  - If t >= d: p = t - d, q = {q,1}. Otherwise p = t, q = {q,0}.
  - x shifts left by 2.
  - When counter == 0, go to DONE; otherwise decrement the counter.
- DONE, one cycle:
  - done=1; root = q; rem = p truncated to R+1 bits (upper bit guaranteed 0); exact updated.
  - start=1 here is accepted exactly as in IDLE (back-to-back), next state CALC.
  - Otherwise go to IDLE.
- Outputs root/rem/exact are registered. They hold their last result until the next DONE or reset, and do not change during CALC.
- busy = 1 exactly in CALC.
- Latency: start accepted at edge k -> busy high for cycles k+1..k+R -> done high in cycle k+R+1. Throughput is one result per R+1 cycles.
- start while busy is ignored; value changes during CALC have no effect.
- value = 0 -> root 0, rem 0. value = 2^WIDTH-1 -> root 2^R-1, rem 2^(R+1)-2. There is no overflow in any internal path.
- Reset asserted mid-CALC aborts immediately. No done pulse is produced, and outputs return to reset values.

Optional Feature:
- Macro ISQRT_EXACT_FLAG_EN.
- Defined: exact is registered in DONE as (p == 0), i.e. value is a perfect square; it holds like root.
- Undefined: exact is tied to 0, and the comparison logic is not synthesized. Port list is unchanged.

Test Plan:
- WIDTH=6, value=49, start pulse -> busy high 3 cycles, done pulse in 4th cycle after accept; root=7, rem=0, exact=1 (macro on) / 0 (macro off).
- WIDTH=6, sweep value 0..63 with back-to-back starts held in DONE -> each result matches floor-sqrt model. Examples: 50 -> 7,1; 63 -> 7,14; 0 -> 0,0; 1 -> 1,0. Exactly one done per request, no idle gap.
- Accept value=36, then pulse start with value=5 during CALC -> ignored; result root=6, rem=0; only one done pulse.
- Start value=63, drop rst_n low in 2nd CALC cycle -> outputs 0 immediately, no done. After release, start value=9 -> root=3, rem=0.
- WIDTH=16, value=65535 -> done 9 cycles after accept, root=255, rem=510. value=65025 -> root=255, rem=0.
- Idle with start low for 20 cycles after a result -> root/rem/exact hold previous values, busy=0, done=0.
